// File: rtl/mem_wb_if.sv
// Memory-to-write-back stage bus.
// Groups the EX/M inputs and the write-back outputs.
interface mem_wb_if;
   logic        MemWr_M;
   logic        Branch_M;
   logic        Jump_M;
   logic        MemtoReg_M;
   logic        RegWr_M;
   logic        Zero_M;
   logic [31:0] ALUout_M;
   logic [31:0] busB_M;
   logic [31:0] Target_M;
   logic [4:0]  Rd_M;
   logic [4:0]  Rb_M;
   logic        PCSrc_M;
   logic [31:0] Target_out;
   logic        RegWr_WB;
   logic        MemtoReg_WB;
   logic [4:0]  Rd_WB;
   logic [31:0] ALUout_WB;
   logic [31:0] MemData_WB;
   logic [31:0] busW_WB;
   logic        MisalignErr;

   modport master (
      output MemWr_M, Branch_M, Jump_M, MemtoReg_M, RegWr_M, Zero_M,
      output ALUout_M, busB_M, Target_M, Rd_M, Rb_M,
      input  PCSrc_M, Target_out, RegWr_WB, MemtoReg_WB, Rd_WB,
      input  ALUout_WB, MemData_WB, busW_WB, MisalignErr
   );

   modport slave (
      input  MemWr_M, Branch_M, Jump_M, MemtoReg_M, RegWr_M, Zero_M,
      input  ALUout_M, busB_M, Target_M, Rd_M, Rb_M,
      output PCSrc_M, Target_out, RegWr_WB, MemtoReg_WB, Rd_WB,
      output ALUout_WB, MemData_WB, busW_WB, MisalignErr
   );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory access and MEM/WB pipeline register.
// Word-addressed data memory, falling-edge state updates.
module mem_wb_stage #(
   parameter int ADDR_W = 8
) (
   input logic     CLK,
   input logic     Resetn,
   mem_wb_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic              misal;
   logic              is_load;
   logic              fwd;
   logic              we;
   logic [31:0]       wdata;
   logic [31:0]       rdata;

   logic        regwr_q;
   logic        memtoreg_q;
   logic [4:0]  rd_q;
   logic [31:0] alu_q;
   logic [31:0] mdata_q;
   logic        err_q;
   logic [31:0] busw;

   assign idx     = bus.ALUout_M[ADDR_W+1:2];
   assign misal   = |bus.ALUout_M[1:0];
   assign is_load = bus.MemtoReg_M & bus.RegWr_M;
   assign rdata   = mem[idx];

   assign busw = memtoreg_q ? mdata_q : alu_q;

   // store data bypass from the instruction now in write-back
   assign fwd = bus.MemWr_M & regwr_q & (rd_q != 5'd0)
              & (rd_q == bus.Rb_M);
   assign wdata = fwd ? busw : bus.busB_M;
   assign we    = bus.MemWr_M & Resetn & ~misal;

   always_ff @(negedge CLK) begin
      if (we)
         mem[idx] <= wdata;
   end

   always_ff @(negedge CLK or negedge Resetn) begin
      if (!Resetn) begin
         regwr_q    <= 1'b0;
         memtoreg_q <= 1'b0;
         rd_q       <= 5'd0;
         alu_q      <= 32'd0;
         mdata_q    <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         regwr_q    <= bus.RegWr_M;
         memtoreg_q <= bus.MemtoReg_M;
         rd_q       <= bus.Rd_M;
         alu_q      <= bus.ALUout_M;
         mdata_q    <= rdata;
         if ((bus.MemWr_M | is_load) & misal)
            err_q <= 1'b1;
      end
   end

   assign bus.PCSrc_M     = bus.Jump_M | (bus.Branch_M & bus.Zero_M);
   assign bus.Target_out  = bus.Target_M;
   assign bus.RegWr_WB    = regwr_q;
   assign bus.MemtoReg_WB = memtoreg_q;
   assign bus.Rd_WB       = rd_q;
   assign bus.ALUout_WB   = alu_q;
   assign bus.MemData_WB  = mdata_q;
   assign bus.busW_WB     = busw;
   assign bus.MisalignErr = err_q;
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning log2 of data-memory depth in 32-bit words.
REQ-002 SHALL have port CLK  input  1  the only clock; all state updates on its falling edge.
REQ-003 SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports MemWr_M, Branch_M, Jump_M, MemtoReg_M, RegWr_M, Zero_M  input  1 each  memory-stage control from the EX/M pipeline register.
REQ-005 SHALL have ports ALUout_M, busB_M, Target_M  input  32 each  address/ALU result, store data, branch/jump target.
REQ-006 SHALL have ports Rd_M, Rb_M  input  5 each  destination register, store-data source register.
REQ-007 SHALL have port PCSrc_M  output  1  redirect PC to Target_M.
REQ-008 SHALL have port Target_out  output  32  equal to Target_M.
REQ-009 SHALL have ports RegWr_WB, MemtoReg_WB  output  1 each  registered write-back control.
REQ-010 SHALL have port Rd_WB  output  5  registered destination register.
REQ-011 SHALL have ports ALUout_WB, MemData_WB  output  32 each  registered ALU result and load data.
REQ-012 SHALL have port busW_WB  output  32  write-back data to register file.
REQ-013 SHALL have port MisalignErr  output  1  sticky misaligned-access flag.

Function
REQ-014 SHALL drive PCSrc_M = Jump_M | (Branch_M & Zero_M), combinationally.
REQ-015 SHALL drive Target_out = Target_M, combinationally.
REQ-016 SHALL contain a data memory of 2^ADDR_W x 32 bits, word index ALUout_M[ADDR_W+1:2]; bits above ADDR_W+1 ignored (aliasing wraps).
REQ-017 SHALL read memory combinationally at the current index; the read value is captured into MemData_WB on the falling edge.
REQ-018 SHALL write memory on the falling edge when MemWr_M=1, Resetn=1, and ALUout_M[1:0]=2'b00.
REQ-019 SHALL suppress the write and set MemWr-related MisalignErr=1 when MemWr_M=1 and ALUout_M[1:0]!=0; MisalignErr SHALL also set for a load (MemtoReg_M=1, RegWr_M=1) with ALUout_M[1:0]!=0; the flag holds until reset.
REQ-020 SHALL forward store data: when MemWr_M=1, RegWr_WB=1, Rd_WB!=0 and Rd_WB==Rb_M, written data = busW_WB; otherwise busB_M.
REQ-021 SHALL register RegWr_M, MemtoReg_M, Rd_M, ALUout_M into the *_WB outputs on each falling edge: one-stage latency.
REQ-022 SHALL drive busW_WB = MemtoReg_WB ? MemData_WB : ALUout_WB, combinationally.
REQ-023 SHALL, on a store to the index a load reads in the same cycle, capture the pre-write (old) word into MemData_WB.
REQ-024 SHALL NOT flush or stall; PCSrc_M is consumed upstream for flushing.

Reset
REQ-025 SHALL, while Resetn=0, asynchronously force RegWr_WB=0, MemtoReg_WB=0, Rd_WB=0, ALUout_WB=0, MemData_WB=0, MisalignErr=0.
REQ-026 SHALL NOT write memory while Resetn=0; memory contents are not cleared by reset.
REQ-027 SHALL, on reset asserted mid-cycle with MemWr_M=1, perform no write on the next falling edge.
REQ-028 SHALL resume normal capture on the first falling edge after Resetn rises.

Verification
REQ-029 Store then load: MemWr_M=1, ALUout_M=0x10, busB_M=0xDEADBEEF; next cycle load 0x10, MemtoReg_M=1, RegWr_M=1, Rd_M=5 -> after edge Rd_WB=5, busW_WB=0xDEADBEEF.
REQ-030 Load-store forward: load to Rd_M=3 from a word holding 0x12345678, next cycle store with Rb_M=3, busB_M=0 to 0x20 -> memory[8]=0x12345678; repeat with Rd_WB=0 -> busB_M stored.
REQ-031 Branch/jump: Branch_M=1, Zero_M=0 -> PCSrc_M=0; Zero_M=1 -> 1; Jump_M=1, Branch_M=0 -> 1; Target_out tracks Target_M.
REQ-032 Misaligned store to 0x13 with 0xFFFFFFFF -> memory[4] unchanged, MisalignErr=1, remains 1 across later aligned accesses.
REQ-033 Reset mid-operation: preload memory[2]=0xA5A5A5A5, assert Resetn=0 with MemWr_M=1 to 0x08, busB_M=0 -> all *_WB and MisalignErr 0 immediately, memory[2] still 0xA5A5A5A5 after release.
REQ-034 Address aliasing: ADDR_W=8, store 0x77 to 0x400 -> load from 0x000 returns 0x77.
